// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: one LW/SW word transfer over a req/ack bus, stalling the CPU until done.
// Optional bus-hang abort is built when DMEM_TIMEOUT_EN is defined.
module dmem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state, state_nx;
  logic   access_ok;
  logic   access_bad;
  logic   ack_take;
  logic   tmo_hit;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] tmo_cnt;
`endif

  always_comb begin
    state_nx   = state;
    stall      = 1'b0;
    access_ok  = 1'b0;
    access_bad = 1'b0;
    ack_take   = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read || mem_write) begin
          if ((mem_read && mem_write) || (addr[1:0] != 2'b00)) begin
            access_bad = 1'b1;
          end else begin
            access_ok = 1'b1;
            stall     = 1'b1;
            state_nx  = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_ack) begin
          ack_take = 1'b1;
          state_nx = DONE;
        end
`ifdef DMEM_TIMEOUT_EN
        // The count reflects REQ cycles already spent, so TIMEOUT-1 marks the last one.
        else if (tmo_cnt == TMO_LAST) begin
          tmo_hit  = 1'b1;
          state_nx = DONE;
        end
`endif
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Error responses are registered, so err and the cleared rdata appear the cycle after detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdata     <= '0;
      err       <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      state   <= state_nx;
      bus_req <= (state_nx == REQ);
      err     <= access_bad || tmo_hit;
      if (access_ok) begin
        bus_addr  <= addr;
        bus_wdata <= wdata;
        bus_we    <= mem_write;
      end
      if (ack_take) begin
        rdata <= bus_we ? '0 : bus_rdata;
      end else if (access_bad || tmo_hit) begin
        rdata <= '0;
      end
    end
  end

`ifdef DMEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (access_ok) begin
      tmo_cnt <= '0;
    end else if (state == REQ && !bus_ack) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl; timeout scenario runs only when DMEM_TIMEOUT_EN is defined.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  dmem_access_ctrl #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .err      (err),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_ack  (bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one access and walks it cycle by cycle until stall drops (the DONE cycle).
  // ack_cyc is the REQ cycle (1-based) in which bus_ack pulses; 0 means never.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input int ack_cyc,
                           input logic [31:0] rdat, output int stalls, output logic err_seen);
    int   req_cyc;
    logic done;
    stalls   = 0;
    req_cyc  = 0;
    err_seen = 1'b0;
    done     = 1'b0;
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (err) err_seen = 1'b1;
      if (bus_req) begin
        req_cyc++;
        bus_ack   = (req_cyc == ack_cyc);
        bus_rdata = rdat;
        chk("bus_addr_hold", bus_addr, a);
        chk("bus_we_hold", {31'b0, bus_we}, {31'b0, wr});
        if (wr) chk("bus_wdata_hold", bus_wdata, d);
      end else begin
        bus_ack = 1'b0;
      end
      if (!stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    chk("access_done", {31'b0, done}, 32'd1);
  endtask

  task automatic release_cpu();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  int   st;
  logic es;

  initial begin
    rst_n     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = '0;
    wdata     = '0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_bus_we", {31'b0, bus_we}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    rst_n = 1'b1;

    // LW 0x10, ack in the third REQ cycle: stall N..N+3
    do_access(1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 3, 32'hCAFE_F00D, st, es);
    chk("lw_stall_cycles", st, 32'd4);
    chk("lw_rdata", rdata, 32'hCAFE_F00D);
    chk("lw_bus_req_done", {31'b0, bus_req}, 32'd0);
    chk("lw_bus_addr", bus_addr, 32'h10);
    chk("lw_err_seen", {31'b0, es}, 32'd0);
    release_cpu();

    // SW 0x20 with same-cycle ack: minimum stall, rdata cleared
    do_access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1, 32'hFFFF_FFFF, st, es);
    chk("sw_stall_cycles", st, 32'd2);
    chk("sw_rdata", rdata, 32'h0);
    chk("sw_bus_we", {31'b0, bus_we}, 32'd1);
    chk("sw_bus_wdata", bus_wdata, 32'h1234_5678);
    chk("sw_err_seen", {31'b0, es}, 32'd0);
    release_cpu();

    // Reload rdata so the error path visibly clears it
    do_access(1'b1, 1'b0, 32'h0000_0008, 32'h0, 2, 32'hA5A5_A5A5, st, es);
    chk("lw2_stall_cycles", st, 32'd3);
    chk("lw2_rdata", rdata, 32'hA5A5_A5A5);
    release_cpu();

    // Misaligned LW
    @(negedge clk);
    mem_read = 1'b1;
    addr     = 32'h0000_0013;
    #1;
    chk("mis_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    chk("mis_err", {31'b0, err}, 32'd1);
    chk("mis_rdata", rdata, 32'h0);
    chk("mis_bus_req", {31'b0, bus_req}, 32'd0);
    chk("mis_stall2", {31'b0, stall}, 32'd0);
    release_cpu();
    @(negedge clk);
    chk("mis_err_pulse", {31'b0, err}, 32'd0);

    // Conflicting read+write at an aligned address
    mem_read  = 1'b1;
    mem_write = 1'b1;
    addr      = 32'h0000_0040;
    #1;
    chk("cfl_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    chk("cfl_err", {31'b0, err}, 32'd1);
    chk("cfl_bus_req", {31'b0, bus_req}, 32'd0);
    chk("cfl_rdata", rdata, 32'h0);
    release_cpu();
    @(negedge clk);
    chk("cfl_err_pulse", {31'b0, err}, 32'd0);

    // Reset two cycles into REQ
    mem_read = 1'b1;
    addr     = 32'h0000_0030;
    @(negedge clk);
    chk("rreq_bus_req1", {31'b0, bus_req}, 32'd1);
    @(negedge clk);
    chk("rreq_bus_req2", {31'b0, bus_req}, 32'd1);
    rst_n = 1'b0;
    release_cpu();
    @(negedge clk);
    chk("rreq_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rreq_stall", {31'b0, stall}, 32'd0);
    chk("rreq_err", {31'b0, err}, 32'd0);
    rst_n = 1'b1;
    do_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 2, 32'h5A5A_1234, st, es);
    chk("post_rst_stall", st, 32'd3);
    chk("post_rst_rdata", rdata, 32'h5A5A_1234);
    release_cpu();

    // Stray ack while idle
    @(negedge clk);
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("stray_rdata", rdata, 32'h5A5A_1234);
    chk("stray_bus_req", {31'b0, bus_req}, 32'd0);
    chk("stray_err", {31'b0, err}, 32'd0);
    chk("stray_stall", {31'b0, stall}, 32'd0);

`ifdef DMEM_TIMEOUT_EN
    // No ack: four REQ cycles then abort into DONE with err
    do_access(1'b1, 1'b0, 32'h0000_0050, 32'h0, 0, 32'h0, st, es);
    chk("tmo_stall_cycles", st, 32'd5);
    chk("tmo_err", {31'b0, err}, 32'd1);
    chk("tmo_rdata", rdata, 32'h0);
    chk("tmo_bus_req", {31'b0, bus_req}, 32'd0);
    release_cpu();
    @(negedge clk);
    chk("tmo_err_pulse", {31'b0, err}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
